// File: rtl/ham_pkg.sv
// Shared widths, codeword bit positions and the output flop-bank layout for the Hamming(7,4) encoder.
package ham_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;

  // Codeword position 1 sits in bit 6, position 7 in bit 0.
  localparam int P1_BIT = 6;
  localparam int P2_BIT = 5;
  localparam int D1_BIT = 4;
  localparam int P4_BIT = 3;
  localparam int D2_BIT = 2;
  localparam int D3_BIT = 1;
  localparam int D4_BIT = 0;

  typedef struct packed {
    logic              vld;
    logic [CODE_W-1:0] dat;
  } out_t;

endpackage

// File: rtl/ham_parity.sv
// Combinational Hamming(7,4) encoder with even parity.
// Zero latency; there is no backpressure path.
module ham_parity
  import ham_pkg::*;
(
  input  logic [DATA_W-1:0] nib,
  output logic [CODE_W-1:0] code
);

  logic d1, d2, d3, d4;

  assign d1 = nib[3];
  assign d2 = nib[2];
  assign d3 = nib[1];
  assign d4 = nib[0];

  always_comb begin
    code         = '0;
    code[P1_BIT] = d1 ^ d2 ^ d4;
    code[P2_BIT] = d1 ^ d3 ^ d4;
    code[D1_BIT] = d1;
    code[P4_BIT] = d2 ^ d3 ^ d4;
    code[D2_BIT] = d2;
    code[D3_BIT] = d3;
    code[D4_BIT] = d4;
  end

endmodule

// File: rtl/ham.sv
// Hamming(7,4) encoder; OUT_REG=1 gives one-cycle latency, OUT_REG=0 is purely combinational.
// Accepts one nibble per cycle and never stalls; an invalid cycle holds the last codeword.
module ham
  import ham_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_dat,
  input  logic              in_valid,
  output logic [CODE_W-1:0] true_dat,
  output logic              out_valid
);

  logic [CODE_W-1:0] code;

  ham_parity u_parity (
    .nib  (in_dat),
    .code (code)
  );

  if (OUT_REG) begin : g_reg
    out_t out_d;
    out_t out_q;

    always_comb begin
      out_d     = out_q;
      out_d.vld = 1'b0;
      if (in_valid) begin
        out_d.vld = 1'b1;
        out_d.dat = code;
      end
    end

    // Reset clears both codeword and valid, dropping any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else begin
        out_q <= out_d;
      end
    end

    assign true_dat  = out_q.dat;
    assign out_valid = out_q.vld;
  end else begin : g_comb
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst_n;
    assign true_dat       = code;
    assign out_valid      = in_valid;
  end

endmodule

// File: tb/tb_ham.sv
// Scoreboard bench for ham: registered and combinational builds side by side.
module tb_ham;

  typedef struct packed {
    logic       vld;
    logic [6:0] dat;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_dat;
  logic       in_valid;
  logic [6:0] true_dat;
  logic       out_valid;

  logic [3:0] in_dat_c;
  logic       in_valid_c;
  logic [6:0] true_dat_c;
  logic       out_valid_c;

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;
  exp_t        sb[$];
  logic [6:0]  last_dat = '0;
  logic [6:0]  obs_code[16];

  ham #(.OUT_REG(1'b1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dat    (in_dat),
    .in_valid  (in_valid),
    .true_dat  (true_dat),
    .out_valid (out_valid)
  );

  ham #(.OUT_REG(1'b0)) u_dut_comb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dat    (in_dat_c),
    .in_valid  (in_valid_c),
    .true_dat  (true_dat_c),
    .out_valid (out_valid_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: data at positions 3,5,6,7; parity at 2^k covers positions with bit k set.
  function automatic logic [6:0] ref_enc(input logic [3:0] nib);
    logic [7:1] c;
    logic [6:0] r;
    c    = '0;
    c[3] = nib[3];
    c[5] = nib[2];
    c[6] = nib[1];
    c[7] = nib[0];
    for (int p = 1; p <= 4; p = p * 2) begin
      for (int k = 3; k <= 7; k++) begin
        if ((k & p) != 0) c[p] = c[p] ^ c[k];
      end
    end
    for (int pos = 1; pos <= 7; pos++) r[7-pos] = c[pos];
    return r;
  endfunction

  function automatic int hdist(input logic [6:0] a, input logic [6:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 7; i++) if (a[i] != b[i]) n++;
    return n;
  endfunction

  // Called just after a rising edge: drive, queue expectation, compare after the next edge.
  task automatic drive(input string tag, input logic [3:0] nib, input logic vld,
                       input logic [6:0] code);
    exp_t e;
    in_dat   = nib;
    in_valid = vld;
    e.vld    = vld;
    e.dat    = vld ? code : last_dat;
    if (vld) last_dat = code;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_dat"}, {25'd0, true_dat}, {25'd0, e.dat});
      check({tag, "_vld"}, {31'd0, out_valid}, {31'd0, e.vld});
    end
  endtask

  logic [3:0] kv_nib[7];
  logic [6:0] kv_code[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    kv_nib  = '{4'b1000, 4'b0100, 4'b1101, 4'b0010, 4'b1010, 4'b1110, 4'b0001};
    kv_code = '{7'b1110000, 7'b1001100, 7'b1010101, 7'b0101010,
                7'b1011010, 7'b0010110, 7'b1101001};

    rst_n      = 1'b0;
    in_dat     = 4'h0;
    in_valid   = 1'b0;
    in_dat_c   = 4'h0;
    in_valid_c = 1'b0;

    #3;
    check("rst_dat", {25'd0, true_dat}, 32'd0);
    check("rst_vld", {31'd0, out_valid}, 32'd0);
    in_dat   = 4'hF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_dat", {25'd0, true_dat}, 32'd0);
    check("rst_hold_vld", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    drive("rel", 4'h0, 1'b0, 7'h00);

    for (int i = 0; i < 7; i++) drive("kv", kv_nib[i], 1'b1, kv_code[i]);

    for (int i = 0; i < 16; i++) begin
      drive("exh", 4'(i), 1'b1, ref_enc(4'(i)));
      obs_code[i] = true_dat;
    end
    check("zero_cw", {25'd0, obs_code[0]}, 32'h00);
    check("ones_cw", {25'd0, obs_code[15]}, 32'h7F);
    for (int i = 0; i < 16; i++) begin
      for (int j = i + 1; j < 16; j++) begin
        check("dist_ge3", {31'd0, hdist(obs_code[i], obs_code[j]) >= 3}, 32'd1);
      end
    end

    drive("hold_a", 4'b1101, 1'b1, 7'b1010101);
    drive("hold_b", 4'b0010, 1'b0, 7'b0000000);
    drive("hold_c", 4'b0111, 1'b0, 7'b0000000);
    drive("b2b_a", 4'b0011, 1'b1, ref_enc(4'b0011));

    drive("arst_pre", 4'b1111, 1'b1, 7'b1111111);
    in_dat   = 4'b1111;
    in_valid = 1'b1;
    #2;
    rst_n    = 1'b0;
    last_dat = '0;
    #1;
    check("arst_dat", {25'd0, true_dat}, 32'd0);
    check("arst_vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("arst_edge_dat", {25'd0, true_dat}, 32'd0);
    check("arst_edge_vld", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    drive("arst_rel", 4'b1111, 1'b1, 7'b1111111);
    drive("arst_next", 4'b0110, 1'b1, ref_enc(4'b0110));

    in_dat_c   = 4'b0100;
    in_valid_c = 1'b1;
    #1;
    check("comb_a_dat", {25'd0, true_dat_c}, {25'd0, 7'b1001100});
    check("comb_a_vld", {31'd0, out_valid_c}, 32'd1);
    in_dat_c   = 4'b0001;
    in_valid_c = 1'b0;
    #1;
    check("comb_b_dat", {25'd0, true_dat_c}, {25'd0, 7'b1101001});
    check("comb_b_vld", {31'd0, out_valid_c}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      in_dat_c = 4'(i);
      #1;
      check("comb_exh", {25'd0, true_dat_c}, {25'd0, ref_enc(4'(i))});
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ham.md
HAM -- requirements
Module: ham

Interface
REQ-001 Parameter: OUT_REG, default 1, meaning 1 = registered output with one-cycle latency, 0 = combinational output with out_valid mirroring in_valid.
REQ-002 Port: clk  input  1  single clock, rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: in_dat  input  4  data nibble, d1=in_dat[3], d2=in_dat[2], d3=in_dat[1], d4=in_dat[0].
REQ-005 Port: in_valid  input  1  in_dat qualifier; tie high for continuous encoding.
REQ-006 Port: true_dat  output  7  Hamming(7,4) codeword, positions 1..7 mapped to true_dat[6:0].
REQ-007 Port: out_valid  output  1  true_dat holds the codeword of an accepted nibble.
REQ-008 Clock and reset: one clock; reset is asynchronous and active-low.

Function
REQ-009 Parity: p1 = d1^d2^d4; p2 = d1^d3^d4; p4 = d2^d3^d4 (even parity).
REQ-010 Codeword order: true_dat = {p1, p2, d1, p4, d2, d3, d4}, MSB first (position 1 = bit 6).
REQ-011 OUT_REG=1: on each rising clk with in_valid=1, true_dat loads the codeword of in_dat; out_valid goes 1 the same edge; latency exactly one cycle.
REQ-012 OUT_REG=1: on a rising clk with in_valid=0, true_dat holds its value and out_valid goes 0.
REQ-013 Back-to-back valid nibbles: one codeword per cycle, no bubbles, no stall input.
REQ-014 OUT_REG=0: true_dat is a pure combinational function of in_dat; out_valid equals in_valid; clk and rst_n unused.
REQ-015 Every bit of true_dat is fully defined for all 16 inputs; no X propagation from a known in_dat.
REQ-016 Minimum Hamming distance between any two of the 16 codewords is 3.

Reset
REQ-017 While rst_n=0: true_dat = 7'b0000000 and out_valid = 0, immediately and independent of clk.
REQ-018 Reset asserted mid-stream discards the pending codeword; the first rising clk after rst_n deasserts with in_valid=1 produces a fresh codeword.
REQ-019 Reset deassertion does not by itself raise out_valid.

Structure
REQ-020 Shared package ham_pkg holds DATA_W=4, CODE_W=7 and the bit-position constants for p1, p2, d1, p4, d2, d3, d4.
REQ-021 One combinational sub-module ham_parity (4-bit in, 7-bit codeword out) implements REQ-009/010; ham adds the output register and valid logic around it.
REQ-022 Output register is a single 8-bit flop bank (true_dat plus out_valid) with asynchronous clear.

Verification
REQ-023 Known vectors, OUT_REG=1, in_valid=1: 1000->1110000, 0100->1001100, 1101->1010101, 0010->0101010, 1010->1011010, 1110->0010110, 0001->1101001, each visible one clock after application.
REQ-024 Exhaustive: all 16 nibbles -> codewords match a reference model; 0000->0000000, 1111->1111111; pairwise distance >= 3.
REQ-025 Hold: apply 1101 valid, then 0010 with in_valid=0 -> true_dat stays 1010101, out_valid drops to 0.
REQ-026 Async reset: drive 1111 valid, assert rst_n=0 between clock edges -> true_dat=0000000, out_valid=0 before the next edge; release -> next valid edge gives correct codeword.
REQ-027 Combinational build OUT_REG=0: change in_dat 0100->0001 -> true_dat 1001100->1101001 with no clock edge.
